// File: rtl/ifu_prefetch.sv
// Instruction fetch with a DEPTH-entry prefetch queue; entries are visible to decode right after the push edge.
// Fetch stalls when queued plus in-flight words would exceed DEPTH; redirects flush the queue and drop stale responses.
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] START_ADDR = 32'h0000_3000,
  parameter logic [31:0] END_ADDR   = 32'h0000_6ffc,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        i_inst_req,
  output logic [31:0] i_inst_addr,
  input  logic        i_inst_gnt,
  input  logic        i_inst_rvalid,
  input  logic [31:0] i_inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        req,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  output logic        d_valid,
  output logic [31:0] d_inst,
  output logic [31:0] d_pc,
  output logic        d_adel,
  input  logic        d_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ISSUE, WAIT, HALT, DRAIN} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [DEPTH-1:0] q_adel;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        redirect;
  logic [31:0] target;
  logic        pc_legal;
  logic        space;
  logic        fetch_adel;
  logic        push_resp;
  logic        push;
  logic        pop;
  logic        granted;

  assign redirect = req | D_eret | redirect_valid;
  assign target   = req ? HANDLER_PC : (D_eret ? EPC : redirect_pc);
  assign pc_legal = (pc[1:0] == 2'b00) && (pc >= START_ADDR) && (pc <= END_ADDR);

  // Only ISSUE evaluates space, and nothing is outstanding there, so count alone decides.
  assign space      = count < FULL;
  assign i_inst_req = !reset && (state == ISSUE) && space && pc_legal;
  assign i_inst_addr = pc;
  assign granted    = i_inst_req && i_inst_gnt;
  assign fetch_adel = (state == ISSUE) && space && !pc_legal;
  assign push_resp  = (state == WAIT) && i_inst_rvalid;
  assign push       = !redirect && (fetch_adel || push_resp);
  assign pop        = !redirect && d_valid && d_ready;

  assign d_valid = (count != '0);
  assign d_inst  = d_valid ? q_inst[rd_ptr] : 32'd0;
  assign d_pc    = d_valid ? q_pc[rd_ptr]   : 32'd0;
  assign d_adel  = d_valid ? q_adel[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= push_resp ? i_inst_rdata : 32'd0;
      q_pc[wr_ptr]   <= push_resp ? req_pc : pc;
      q_adel[wr_ptr] <= !push_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ISSUE;
      pc     <= RESET_PC;
      req_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= target;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // A granted or still-pending fetch must be drained before refetching.
      case (state)
        ISSUE:   state <= granted ? DRAIN : ISSUE;
        WAIT:    state <= i_inst_rvalid ? ISSUE : DRAIN;
        HALT:    state <= ISSUE;
        DRAIN:   state <= i_inst_rvalid ? ISSUE : DRAIN;
        default: state <= ISSUE;
      endcase
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        ISSUE: begin
          if (granted) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end else if (fetch_adel) begin
            state <= HALT;
          end
        end
        WAIT:    if (i_inst_rvalid) state <= ISSUE;
        HALT:    state <= HALT;
        DRAIN:   if (i_inst_rvalid) state <= ISSUE;
        default: state <= ISSUE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: variable-latency memory model, scoreboard of expected decode entries, redirect vector table.
module tb_ifu_prefetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        i_inst_gnt;
  logic        i_inst_rvalid;
  logic [31:0] i_inst_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req;
  logic        D_eret;
  logic [31:0] EPC;
  logic        d_valid;
  logic [31:0] d_inst;
  logic [31:0] d_pc;
  logic        d_adel;
  logic        d_ready;

  int checks = 0;
  int errors = 0;

  logic gnt_en;
  int   gnt_limit;
  int   n_gnt;
  int   lat;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        eret;
    logic [31:0] epc;
    logic        exc;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic        exp_adel;
  } vec_t;
  vec_t vecs[10];

  ifu_prefetch dut (
    .clk(clk), .reset(reset),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr), .i_inst_gnt(i_inst_gnt),
    .i_inst_rvalid(i_inst_rvalid), .i_inst_rdata(i_inst_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req(req), .D_eret(D_eret), .EPC(EPC),
    .d_valid(d_valid), .d_inst(d_inst), .d_pc(d_pc), .d_adel(d_adel), .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic adel);
    exp_t e;
    e.pc = pc;
    e.inst = adel ? 32'd0 : memword(pc);
    e.adel = adel;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget, output int used);
    used = 0;
    while (used < budget && exp_q.size() != 0) begin
      @(negedge clk);
      used++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    req = 1'b0; D_eret = 1'b0; EPC = '0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {i_inst_req, d_valid, d_adel, d_inst, d_pc}, 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("first_req", {i_inst_req, i_inst_addr}, {1'b1, 32'h0000_3000});
  endtask

  assign i_inst_gnt = i_inst_req && gnt_en && (n_gnt < gnt_limit);

  // Memory: grant combinational, response lat cycles after grant, in order.
  initial begin : memory
    logic        fire, rv_now, pend;
    logic [31:0] faddr, paddr;
    int          cnt;
    i_inst_rvalid = 1'b0; i_inst_rdata = '0; pend = 1'b0; n_gnt = 0; cnt = 0; paddr = '0;
    forever begin
      @(negedge clk);
      fire = i_inst_req && i_inst_gnt;
      faddr = i_inst_addr;
      rv_now = i_inst_rvalid;
      @(posedge clk);
      #1;
      if (reset) begin
        pend = 1'b0; i_inst_rvalid = 1'b0; n_gnt = 0;
      end else begin
        if (rv_now) begin i_inst_rvalid = 1'b0; pend = 1'b0; end
        if (fire) begin pend = 1'b1; paddr = faddr; cnt = lat; n_gnt++; end
        if (pend && !i_inst_rvalid) begin
          cnt--;
          if (cnt <= 0) begin i_inst_rvalid = 1'b1; i_inst_rdata = memword(paddr); end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && d_valid && d_ready && !(req || D_eret || redirect_valid)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra actual pc=%h required no entry", d_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", 64'(d_pc), 64'(mon_e.pc));
        check("sb_inst", 64'(d_inst), 64'(mon_e.inst));
        check("sb_adel", 64'(d_adel), 64'(mon_e.adel));
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    logic any_req;
    vecs[0] = '{1'b1, 32'h0000_3000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3000, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_2ffc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_2ffc, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_6ffc, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_6ffc, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_7000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_7000, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_3102, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_3102, 1'b1};
    vecs[5] = '{1'b0, 32'h0,         1'b1, 32'h0000_7000, 1'b0, 1'b0, 32'h0000_7000, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_3300, 1'b1, 32'h0000_3200, 1'b0, 1'b1, 32'h0000_3200, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_3300, 1'b1, 32'h0000_3200, 1'b1, 1'b1, 32'h0000_4180, 1'b0};
    vecs[8] = '{1'b1, 32'hffff_fffc, 1'b0, 32'h0, 1'b0, 1'b0, 32'hffff_fffc, 1'b1};
    vecs[9] = '{1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_4180, 1'b0};

    // Streaming at full rate.
    gnt_en = 1'b1; gnt_limit = 16; lat = 1; d_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) push_exp(32'h0000_3000 + 32'(4 * i), 1'b0);
    wait_drain("stream_drain", 200, used);
    if (used > 34) begin
      checks++; errors++;
      $display("FAIL stream_rate actual=%0d cycles required<=34", used);
    end else checks++;
    repeat (6) tick();

    // Backpressure fills exactly DEPTH entries.
    gnt_limit = 1000; d_ready = 1'b0;
    do_reset();
    repeat (20) tick();
    @(negedge clk);
    check("bp_noreq", 64'(i_inst_req), 64'd0);
    check("bp_valid", 64'(d_valid), 64'd1);
    check("bp_fetched", 64'(n_gnt), 64'd4);
    gnt_limit = n_gnt;
    for (int i = 0; i < 4; i++) push_exp(32'h0000_3000 + 32'(4 * i), 1'b0);
    tick();
    d_ready = 1'b1;
    wait_drain("bp_drain", 50, used);
    repeat (5) tick();
    @(negedge clk);
    check("bp_empty", 64'(d_valid), 64'd0);

    // Redirect vector table, inspecting the queue head with decode stalled.
    gnt_limit = 100000; d_ready = 1'b0; lat = 1;
    do_reset();
    for (int v = 0; v < 10; v++) begin
      repeat (12) tick();
      redirect_valid = vecs[v].rv; redirect_pc = vecs[v].rpc;
      D_eret = vecs[v].eret; EPC = vecs[v].epc; req = vecs[v].exc;
      tick();
      redirect_valid = 1'b0; D_eret = 1'b0; req = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_flush", v), 64'(d_valid), 64'd0);
      check($sformatf("v%0d_req", v), 64'(i_inst_req), 64'(vecs[v].exp_req));
      if (vecs[v].exp_req) check($sformatf("v%0d_addr", v), 64'(i_inst_addr), 64'(vecs[v].exp_pc));
      used = 0;
      while (used < 10 && !d_valid) begin @(negedge clk); used++; end
      check($sformatf("v%0d_pc", v), {d_valid, d_pc}, {1'b1, vecs[v].exp_pc});
      check($sformatf("v%0d_adel", v), 64'(d_adel), 64'(vecs[v].exp_adel));
      check($sformatf("v%0d_inst", v), 64'(d_inst),
            64'(vecs[v].exp_adel ? 32'd0 : memword(vecs[v].exp_pc)));
    end

    // Redirect while a 3-cycle fetch is pending: stale word dropped.
    lat = 3; gnt_limit = 3; d_ready = 1'b1;
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3100;
    push_exp(32'h0000_3100, 1'b0);
    push_exp(32'h0000_3104, 1'b0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("drain_noreq", 64'(i_inst_req), 64'd0);
    used = 0;
    while (used < 10 && !i_inst_req) begin @(negedge clk); used++; end
    check("drain_addr", {i_inst_req, i_inst_addr}, {1'b1, 32'h0000_3100});
    wait_drain("drain_sb", 60, used);
    repeat (6) tick();

    // Misaligned target halts until exception entry.
    lat = 1; gnt_en = 1'b0; gnt_limit = 100000;
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3102;
    tick();
    redirect_valid = 1'b0; gnt_en = 1'b1;
    push_exp(32'h0000_3102, 1'b1);
    any_req = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); any_req |= i_inst_req; end
    check("halt_noreq", 64'(any_req), 64'd0);
    wait_drain("halt_sb", 10, used);
    tick();
    req = 1'b1;
    gnt_limit = n_gnt + 2;
    push_exp(32'h0000_4180, 1'b0);
    push_exp(32'h0000_4184, 1'b0);
    tick();
    req = 1'b0;
    @(negedge clk);
    check("exc_addr", {i_inst_req, i_inst_addr}, {1'b1, 32'h0000_4180});
    wait_drain("exc_sb", 40, used);
    repeat (4) tick();

    // Top of the legal window, then AdEL just past it.
    gnt_en = 1'b0; gnt_limit = 100000;
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_6ff8;
    tick();
    redirect_valid = 1'b0; gnt_en = 1'b1;
    push_exp(32'h0000_6ff8, 1'b0);
    push_exp(32'h0000_6ffc, 1'b0);
    push_exp(32'h0000_7000, 1'b1);
    wait_drain("end_sb", 40, used);
    any_req = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); any_req |= i_inst_req; end
    check("end_halt", 64'(any_req), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit with a decoupled prefetch queue. It owns the fetch PC and issues word fetches to instruction memory over a request/grant/response handshake that tolerates variable latency. Fetched words, their PCs and an address-error flag are buffered in a `DEPTH`-entry FIFO that the decode stage drains. It sits between instruction memory and D, and accepts redirects from branch resolution, exception entry and `eret`.

## Interface
- `RESET_PC`, 32'h0000_3000, fetch PC after reset
- `START_ADDR`, 32'h0000_3000, lowest legal instruction address
- `END_ADDR`, 32'h0000_6ffc, highest legal instruction address
- `HANDLER_PC`, 32'h0000_4180, exception entry address
- `DEPTH`, 4, queue entries; power of two, ≥2

- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `i_inst_req` out 1: fetch request
- `i_inst_addr` out 32: fetch address; held stable while `i_inst_req`=1 and no grant
- `i_inst_gnt` in 1: memory accepts request this cycle
- `i_inst_rvalid` in 1: response valid; in order; at the earliest 1 cycle after grant
- `i_inst_rdata` in 32: response word
- `redirect_valid` in 1: branch/jump redirect
- `redirect_pc` in 32: redirect target
- `req` in 1: exception/interrupt entry; target `HANDLER_PC`
- `D_eret` in 1: eret redirect
- `EPC` in 32: eret target
- `d_valid` out 1: queue head valid
- `d_inst` out 32: head instruction (0 when `d_adel`)
- `d_pc` out 32: head PC
- `d_adel` out 1: head fetch address was illegal
- `d_ready` in 1: decode consumes head when `d_valid`=1

## Operation
- Redirect priority: `req` > `D_eret` > `redirect_valid`. Any redirect flushes the queue, sets fetch PC to the target and cancels HALT.
- Legal address: `addr[1:0]`==0 and `START_ADDR` ≤ addr ≤ `END_ADDR`, unsigned.
- Space condition: queue count + outstanding (0/1) < `DEPTH`. At most one transaction is outstanding.
- States:
  - ISSUE: if space is available and the PC is legal, `i_inst_req`=1 with `i_inst_addr`=fetch PC. On grant, go to WAIT and set PC to PC+4 (wraps modulo 2^32). If space is available and the PC is illegal, there is no request. Instead push {inst=0, pc, adel=1} and go to HALT.
  - WAIT: on `rvalid`, push {rdata, pc of request, adel=0} and go to ISSUE.
  - HALT: no requests until a redirect arrives; then go to ISSUE.
  - DRAIN: a stale transaction is in flight. On `rvalid`, discard the data and go to ISSUE.
- A redirect in WAIT, or in ISSUE on the same cycle as a grant, goes to DRAIN. A redirect in WAIT on the same cycle as `rvalid` drops the data and goes to ISSUE. A redirect in DRAIN stays in DRAIN and updates the PC.
- Queue pop: `d_valid && d_ready`. Push and pop in the same cycle are allowed, including when the queue is full. The space reservation guarantees that a push never overflows.
- Redirect cycle: the flush overrides the push and pop of that cycle; the count becomes 0.

## Timing
- Reset values: `i_inst_req`=0, `d_valid`=0, `d_inst`=0, `d_pc`=0, `d_adel`=0; fetch PC=`RESET_PC`; state ISSUE; count 0.
- The first request is asserted in the first cycle after reset deasserts.
- Zero-stall throughput with grant in the request cycle and rvalid in the next cycle: one word every 2 cycles.
- Fetch-to-decode latency: an entry pushed at edge N is visible (`d_valid`=1) immediately after edge N.
- After a redirect edge, `d_valid`=0 for at least 1 cycle. The new request starts in the next cycle, unless the unit is in DRAIN.
- Reset in mid-transaction returns to the reset state immediately. The bench does not drive a stale `rvalid` after reset.

## Test plan
- Reset, then memory with grant in the same cycle and 1-cycle rvalid, `d_ready`=1 -> `d_pc` sequence 0x3000, 0x3004, 0x3008…; `d_inst` matches memory; `d_adel`=0.
- `d_ready`=0 for 20 cycles -> exactly `DEPTH` (4) entries buffered, then `i_inst_req` stays 0. Release -> pops in order; no loss or duplication.
- `redirect_valid` with target 0x3100 while in WAIT with a 3-cycle rvalid -> stale rdata dropped, queue empty, next request address is 0x3100, and the first `d_pc` after the redirect is 0x3100.
- `redirect_valid` to 0x3102 -> no request; one entry {pc=0x3102, inst=0, adel=1}; no further entries until `req`, then fetch from 0x4180.
- `req`, `D_eret` (EPC=0x3200) and `redirect_valid` in the same cycle -> next request address is 0x4180.
- `D_eret` with EPC=0x7000 -> AdEL entry with pc 0x7000. Separately, PC reaching 0x6ffc -> fetch 0x6ffc normally, then an AdEL entry at 0x7000.
